// File: rtl/data_output.sv
// I2S master transmitter: FIFO of stereo pairs, sck/ws generation, MSB-first sd.
// Optional saturating underflow counter via DATA_OUTPUT_UNDERFLOW_COUNT_EN.
module data_output #(
  parameter int WIDTH      = 24,
  parameter int SLOT       = 32,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_left,
  input  logic [WIDTH-1:0] in_right,
  output logic             sck,
  output logic             ws,
  output logic             sd,
  output logic             underflow,
  output logic [15:0]      underflow_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(2 * SLOT);
  localparam int SW = $clog2(SLOT);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [WIDTH-1:0] mem_l [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;

  logic             run;
  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [BW-1:0]    bit_nxt;
  logic [WIDTH-1:0] left_q;
  logic [WIDTH-1:0] right_q;
  logic [WIDTH-1:0] cur_l;
  logic [WIDTH-1:0] cur_r;
  logic [SLOT-1:0]  word_l;
  logic [SLOT-1:0]  word_r;
  logic [SW-1:0]    pos;
  logic [SW-1:0]    idx;

  logic active;
  logic tick;
  logic fall;
  logic load;
  logic empty;
  logic push;
  logic pop;
  logic in_right_half;
  logic sd_nxt;
  logic ws_nxt;

  // run delays start by one clk so the first sck rise lands CLK_DIV after enable
  assign active = run && enable;
  assign tick   = active && (div_cnt == DIV_LAST);
  assign fall   = tick && sck;
  assign bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
  assign load   = fall && (bit_nxt == '0);
  assign empty  = (count == '0);
  assign push   = in_valid && in_ready;
  assign pop    = load && !empty;

  always_comb begin
    cur_l = left_q;
    cur_r = right_q;
    if (load) begin
      cur_l = empty ? '0 : mem_l[rd_ptr];
      cur_r = empty ? '0 : mem_r[rd_ptr];
    end
  end

  // left-justify each sample in its slot so padding bits read as 0
  always_comb begin
    word_l = SLOT'(cur_l) << (SLOT - WIDTH);
    word_r = SLOT'(cur_r) << (SLOT - WIDTH);
    in_right_half = (bit_nxt >= BW'(SLOT));
    pos = in_right_half ? SW'(bit_nxt - BW'(SLOT)) : SW'(bit_nxt);
    idx = SW'(SLOT - 1) - pos;
    sd_nxt = in_right_half ? word_r[idx] : word_l[idx];
    ws_nxt = (bit_nxt >= BW'(SLOT - 1)) && (bit_nxt <= BW'(2 * SLOT - 2));
  end

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_l[wr_ptr] <= in_left;
      mem_r[wr_ptr] <= in_right;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_nxt;
      in_ready <= (count_nxt != (AW+1)'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run       <= 1'b0;
      div_cnt   <= '0;
      bit_cnt   <= BIT_LAST;
      sck       <= 1'b0;
      ws        <= 1'b0;
      sd        <= 1'b0;
      underflow <= 1'b0;
      left_q    <= '0;
      right_q   <= '0;
    end else begin
      run       <= enable;
      underflow <= 1'b0;
      if (!active) begin
        div_cnt <= '0;
        bit_cnt <= BIT_LAST;
        sck     <= 1'b0;
        ws      <= 1'b0;
        sd      <= 1'b0;
      end else if (tick) begin
        div_cnt <= '0;
        sck     <= !sck;
        if (sck) begin
          bit_cnt   <= bit_nxt;
          sd        <= sd_nxt;
          ws        <= ws_nxt;
          left_q    <= cur_l;
          right_q   <= cur_r;
          underflow <= load && empty;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

`ifdef DATA_OUTPUT_UNDERFLOW_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_count <= '0;
    end else if (load && empty && (underflow_count != 16'hFFFF)) begin
      underflow_count <= underflow_count + 1'b1;
    end
  end
`else
  assign underflow_count = '0;
`endif

endmodule
